register_serializer: RTL and testbench

REGISTER_SERIALIZER -- requirements
Module: register_serializer

---
 rtl/register_serializer_pkg.sv | 19 +
 rtl/register_serializer_if.sv | 37 +++
 rtl/register_serializer_bit_counter.sv | 31 +++
 rtl/register_serializer.sv | 138 +++++++++++++
 tb/tb_register_serializer.sv | 136 +++++++++++++
 5 files changed

// File: rtl/register_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : register_serializer_pkg
//  Description : Shared state encoding for the register serializer and any
//                bench or receiver that needs to interpret its frame states.
//  Revision    : 1.0 - initial release
// ============================================================================
package register_serializer_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t c_IDLE  = 2'd0;
    localparam state_t c_SHIFT = 2'd1;
    localparam state_t c_DONE  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/register_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : register_serializer_if
//  Description : Parallel-in / serial-out handshake bundle. The master side
//                supplies the word and load request; the slave side (the
//                serializer) returns ready, serial data, valid and done.
//  Revision    : 1.0 - initial release
// ============================================================================
interface register_serializer_if #(
    parameter int N = 8
);
    logic [N-1:0] in;
    logic         load;
    logic         ready;
    logic         serial_out;
    logic         valid;
    logic         done;

    modport master (
        output in,
        output load,
        input  ready,
        input  serial_out,
        input  valid,
        input  done
    );

    modport slave (
        input  in,
        input  load,
        output ready,
        output serial_out,
        output valid,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/register_serializer_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bit_counter
//  Description : Up-counter with synchronous clear (priority) and enable.
//                Tracks which bit of the frame is currently on the line.
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_counter #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             i_clr,
    input  wire logic             i_en,
    output logic [WIDTH-1:0]      o_count
);

    logic [WIDTH-1:0] r_count;

    // Clear wins over enable so a new frame always starts from bit 0
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/register_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : register_serializer
//  Description : Captures an N-bit word on load and shifts it out LSB first,
//                one bit per cycle with valid, followed by a one-cycle done
//                pulse. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_serializer
    import register_serializer_pkg::*;
#(
    parameter int N = 8
) (
    input  wire logic             clock,
    input  wire logic             reset,
    register_serializer_if.slave  bus
);

    localparam int              CW     = $clog2(N);
    localparam logic [CW-1:0]   c_LAST = CW'(N - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_shift;
    logic [N-1:0]    w_shift_nxt;
    logic [CW-1:0]   w_count;
    logic            w_accept;
    logic            w_cnt_clr;
    logic            w_cnt_en;

    logic            r_ready;
    logic            r_valid;
    logic            r_done;
    logic            r_serial;
    logic            w_ready_nxt;
    logic            w_valid_nxt;
    logic            w_done_nxt;
    logic            w_serial_nxt;

    assign w_accept  = (r_state == c_IDLE) && bus.load;
    assign w_cnt_clr = ~reset | w_accept;
    // Counter parks on the last index instead of wrapping when the frame ends
    assign w_cnt_en  = (r_state == c_SHIFT) && (w_count != c_LAST);

    bit_counter #(
        .WIDTH (CW)
    ) u_bit_counter (
        .clk     (clock),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    // State register; reset returns to IDLE from anywhere, aborting a frame
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-shift decode
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        case (r_state)
            c_IDLE: begin
                if (bus.load) begin
                    w_state_nxt = c_SHIFT;
                    w_shift_nxt = bus.in;
                end
            end
            c_SHIFT: begin
                w_shift_nxt = r_shift >> 1;
                if (w_count == c_LAST) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_shift_nxt = '0;
            end
        endcase
    end

    // Shift register holds the remaining frame bits, bit 0 is on the line
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_shift <= '0;
        end else begin
            r_shift <= w_shift_nxt;
        end
    end

    // Outputs are decoded from the upcoming state so the registered copies
    // line up with the state they describe
    always_comb begin
        w_ready_nxt  = 1'b0;
        w_valid_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_serial_nxt = 1'b0;
        case (w_state_nxt)
            c_IDLE:  w_ready_nxt = 1'b1;
            c_SHIFT: begin
                w_valid_nxt  = 1'b1;
                w_serial_nxt = w_shift_nxt[0];
            end
            c_DONE:  w_done_nxt = 1'b1;
            default: w_ready_nxt = 1'b0;
        endcase
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
            r_serial <= 1'b0;
        end else begin
            r_ready  <= w_ready_nxt;
            r_valid  <= w_valid_nxt;
            r_done   <= w_done_nxt;
            r_serial <= w_serial_nxt;
        end
    end

    assign bus.ready      = r_ready;
    assign bus.valid      = r_valid;
    assign bus.done       = r_done;
    assign bus.serial_out = r_serial;

endmodule
`default_nettype wire

// File: tb/tb_register_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_serializer
//  Description : Directed, table-driven bench for register_serializer (N=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_serializer;

    localparam int N = 8;

    typedef struct {
        logic         rst_n;
        logic         load;
        logic [N-1:0] din;
        logic         ready;
        logic         valid;
        logic         done;
        logic         ser;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    register_serializer_if #(.N(N)) bus ();

    register_serializer #(
        .N (N)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic l, input logic [N-1:0] d,
                       input logic er, input logic ev, input logic ed, input logic es);
        vec_t v;
        v.rst_n = r;  v.load  = l;  v.din  = d;
        v.ready = er; v.valid = ev; v.done = ed; v.ser = es;
        vecs.push_back(v);
    endtask

    // One frame: accept edge, N-1 further bit cycles, done cycle, back to idle.
    // load/in during the frame are set to the given interference values.
    task automatic add_frame(input logic [N-1:0] data, input logic hold_load,
                             input logic [N-1:0] din_during);
        add(1'b1, 1'b1, data, 1'b0, 1'b1, 1'b0, data[0]);
        for (int k = 1; k < N; k++) begin
            add(1'b1, hold_load, din_during, 1'b0, 1'b1, 1'b0, data[k]);
        end
        add(1'b1, hold_load, din_during, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b1, hold_load, din_during, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check(input string name, input logic got, input logic want, input int idx);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step %0d %s: got %b want %b", idx, name, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst_n    = v.rst_n;
        bus.load = v.load;
        bus.in   = v.din;
        @(posedge clk);
        #1;
        check("ready",      bus.ready,      v.ready, idx);
        check("valid",      bus.valid,      v.valid, idx);
        check("done",       bus.done,       v.done,  idx);
        check("serial_out", bus.serial_out, v.ser,   idx);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        bus.load = 1'b0;
        bus.in   = '0;

        // Reset for two cycles (second with load asserted, which must be ignored)
        add(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        // Basic 0x0A frame: 0,1,0,1,0,0,0,0 then done then ready
        add_frame(8'h0A, 1'b0, 8'h0A);
        // Frame 0x0A with in=0xFF and load held during SHIFT/DONE
        add_frame(8'h0A, 1'b1, 8'hFF);
        add(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
        // Back-to-back 0xA5 frames with load held high
        add_frame(8'hA5, 1'b1, 8'hA5);
        add_frame(8'hA5, 1'b1, 8'hA5);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        // All-ones then all-zeros frames
        add_frame(8'hFF, 1'b0, 8'h00);
        add_frame(8'h00, 1'b0, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset on the 4th valid cycle of a 0x96 frame (bits 0,1,1,0,...):
        // outputs must drop straight to idle with no done pulse.
        vecs.delete();
        add(1'b1, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        // Fresh frame after the abort must be intact
        add_frame(8'h3C, 1'b0, 8'h00);
        add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], 1000 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
